// File: rtl/param_buff_arbiter_if.sv
// Loader, EPU, readback and SRAM buses of param_buff_arbiter.
// slave is the arbiter's view; master is the view of the blocks around it.
interface param_buff_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_wdata_i;

  logic              epu_req_i;
  logic              epu_we_i;
  logic [ADDR_W-1:0] epu_addr_i;
  logic [DATA_W-1:0] epu_wdata_i;
  logic              epu_gnt_o;
  logic              epu_rvalid_o;
  logic [DATA_W-1:0] epu_rdata_o;

  logic              rb_req_i;
  logic [ADDR_W-1:0] rb_addr_i;
  logic              rb_gnt_o;
  logic              rb_rvalid_o;
  logic [DATA_W-1:0] rb_rdata_o;

  logic              sram_cs_o;
  logic              sram_oe_o;
  logic              sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_wdata_o;
  logic [DATA_W-1:0] sram_rdata_i;

  modport slave (
    input  ld_valid_i, ld_addr_i, ld_wdata_i,
    input  epu_req_i, epu_we_i, epu_addr_i, epu_wdata_i,
    input  rb_req_i, rb_addr_i, sram_rdata_i,
    output ld_ready_o, epu_gnt_o, epu_rvalid_o, epu_rdata_o,
    output rb_gnt_o, rb_rvalid_o, rb_rdata_o,
    output sram_cs_o, sram_oe_o, sram_we_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output ld_valid_i, ld_addr_i, ld_wdata_i,
    output epu_req_i, epu_we_i, epu_addr_i, epu_wdata_i,
    output rb_req_i, rb_addr_i, sram_rdata_i,
    input  ld_ready_o, epu_gnt_o, epu_rvalid_o, epu_rdata_o,
    input  rb_gnt_o, rb_rvalid_o, rb_rdata_o,
    input  sram_cs_o, sram_oe_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/param_buff_arbiter.sv
// Single-port parameter SRAM arbiter: loader writes in LOAD, EPU accesses in RUN.
// Define PARAM_ARB_READBACK_EN to enable SRAM readback during LOAD.
module param_buff_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  output logic              ld_done_o,
  output logic [1:0]        state_o,
  param_buff_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] cnt_nxt;
  logic            ld_done;
  logic            epu_rvalid;
  logic            rb_rvalid;

  logic            act;
  logic            ld_ready;
  logic            beat;
  logic            epu_gnt;
  logic            rb_gnt;

  assign act     = rst & enb_i;
  assign cnt_nxt = cnt + (ADDR_W+1)'(1);

  // A beat is dropped when a restart coincides with it or the phase is already complete.
  always_comb begin
    ld_ready = act && (state == LOAD);
    beat     = ld_ready && bus.ld_valid_i && !load_start_i && (cnt != len);
    epu_gnt  = act && (state == RUN) && bus.epu_req_i && !load_start_i;
`ifdef PARAM_ARB_READBACK_EN
    rb_gnt   = ld_ready && bus.rb_req_i && !bus.ld_valid_i;
`else
    rb_gnt   = 1'b0;
`endif
  end

  always_comb begin
    bus.sram_cs_o    = 1'b0;
    bus.sram_oe_o    = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    if (beat) begin
      bus.sram_cs_o    = 1'b1;
      bus.sram_we_o    = 1'b1;
      bus.sram_addr_o  = bus.ld_addr_i;
      bus.sram_wdata_o = bus.ld_wdata_i;
    end else if (epu_gnt) begin
      bus.sram_cs_o    = 1'b1;
      bus.sram_oe_o    = !bus.epu_we_i;
      bus.sram_we_o    = bus.epu_we_i;
      bus.sram_addr_o  = bus.epu_addr_i;
      bus.sram_wdata_o = bus.epu_wdata_i;
    end else if (rb_gnt) begin
      bus.sram_cs_o    = 1'b1;
      bus.sram_oe_o    = 1'b1;
      bus.sram_addr_o  = bus.rb_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      ld_done    <= 1'b0;
      epu_rvalid <= 1'b0;
      rb_rvalid  <= 1'b0;
    end else begin
      ld_done    <= 1'b0;
      epu_rvalid <= epu_gnt && !bus.epu_we_i;
      rb_rvalid  <= rb_gnt;
      if (enb_i) begin
        if (load_start_i) begin
          state <= LOAD;
          cnt   <= '0;
          len   <= load_len_i;
        end else if (state == LOAD) begin
          // cnt == len here only for a zero-length load
          if (cnt == len) begin
            state   <= RUN;
            ld_done <= 1'b1;
          end else if (beat) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == len) begin
              state   <= RUN;
              ld_done <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign state_o          = state;
  assign ld_done_o        = ld_done;
  assign bus.ld_ready_o   = ld_ready;
  assign bus.epu_gnt_o    = epu_gnt;
  assign bus.epu_rvalid_o = epu_rvalid;
  assign bus.epu_rdata_o  = epu_rvalid ? bus.sram_rdata_i : '0;

`ifdef PARAM_ARB_READBACK_EN
  assign bus.rb_gnt_o     = rb_gnt;
  assign bus.rb_rvalid_o  = rb_rvalid;
  assign bus.rb_rdata_o   = rb_rvalid ? bus.sram_rdata_i : '0;
`else
  logic unused_rb;
  assign unused_rb        = ^{bus.rb_req_i, bus.rb_addr_i, rb_gnt, rb_rvalid};
  assign bus.rb_gnt_o     = 1'b0;
  assign bus.rb_rvalid_o  = 1'b0;
  assign bus.rb_rdata_o   = '0;
`endif

endmodule

// File: tb/tb_param_buff_arbiter.sv
// Self-checking bench for param_buff_arbiter with a behavioural SRAM and reference memory.
module tb_param_buff_arbiter;

  logic        clk;
  logic        rst;
  logic        enb;
  logic        load_start;
  logic [4:0]  load_len;
  logic        ld_done;
  logic [1:0]  state;

  param_buff_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  param_buff_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enb_i        (enb),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .ld_done_o    (ld_done),
    .state_o      (state),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [38:0] sram_bus;

  assign sram_bus = {bus.sram_cs_o, bus.sram_oe_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: read data valid the cycle after a read, garbage otherwise
  always @(posedge clk) begin
    if (bus.sram_cs_o && bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
    if (bus.sram_cs_o && bus.sram_oe_o && !bus.sram_we_o) bus.sram_rdata_i <= mem[bus.sram_addr_o];
    else bus.sram_rdata_i <= $urandom;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [38:0] wr(input logic [3:0] a, input logic [31:0] d);
    return {3'b101, a, d};
  endfunction

  function automatic logic [38:0] rd(input logic [3:0] a, input logic [31:0] d);
    return {3'b110, a, d};
  endfunction

  task automatic idle_inputs();
    enb = 1'b1; load_start = 1'b0; load_len = '0;
    bus.ld_valid_i = 1'b0; bus.ld_addr_i = '0; bus.ld_wdata_i = '0;
    bus.epu_req_i = 1'b0; bus.epu_we_i = 1'b0; bus.epu_addr_i = '0; bus.epu_wdata_i = '0;
    bus.rb_req_i = 1'b0; bus.rb_addr_i = '0;
  endtask

  task automatic start_load(input int n);
    @(negedge clk); idle_inputs(); load_start = 1'b1; load_len = 5'(n);
  endtask

  task automatic beat(input logic [3:0] a, input logic [31:0] d, input string nm);
    @(negedge clk); idle_inputs(); bus.ld_valid_i = 1'b1; bus.ld_addr_i = a; bus.ld_wdata_i = d; #1;
    checks++; if (sram_bus !== wr(a, d)) begin errors++; $display("FAIL %s_write: got %h expected %h", nm, sram_bus, wr(a, d)); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL %s_no_done: got %b expected 0", nm, ld_done); end
    ref_mem[a] = d;
  endtask

  task automatic expect_done(input string nm);
    @(negedge clk); idle_inputs(); #1;
    checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", nm, ld_done); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL %s_run: got %b expected 10", nm, state); end
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
    checks++; if ({ld_done, bus.epu_rvalid_o, bus.rb_rvalid_o, bus.ld_ready_o, bus.epu_gnt_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {ld_done, bus.epu_rvalid_o, bus.rb_rvalid_o, bus.ld_ready_o, bus.epu_gnt_o}); end
    checks++; if ({bus.epu_rdata_o, bus.rb_rdata_o, sram_bus} !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.epu_rdata_o, bus.rb_rdata_o, sram_bus}); end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    @(negedge clk); idle_inputs(); bus.epu_req_i = 1'b1; bus.epu_addr_i = 4'd3; bus.ld_valid_i = 1'b1; #1;
    checks++; if ({bus.epu_gnt_o, bus.ld_ready_o} !== 2'b00) begin errors++; $display("FAIL idle_gnt: got %b expected 00", {bus.epu_gnt_o, bus.ld_ready_o}); end
    checks++; if (sram_bus !== '0) begin errors++; $display("FAIL idle_sram: got %h expected 0", sram_bus); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({bus.epu_rvalid_o, state} !== 3'b000) begin errors++; $display("FAIL idle_after: got %b expected 000", {bus.epu_rvalid_o, state}); end
  endtask

  task automatic test_load_basic();
    start_load(4);
    for (int i = 0; i < 4; i++) begin
      beat(4'(i), 32'hA0 + 32'(i), "basic");
      checks++; if ({bus.ld_ready_o, state} !== 3'b101) begin errors++; $display("FAIL basic_ready: got %b expected 101", {bus.ld_ready_o, state}); end
    end
    expect_done("basic");
    @(negedge clk); idle_inputs(); #1;
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", ld_done); end
  endtask

  task automatic test_epu_read();
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk); idle_inputs(); bus.epu_req_i = 1'b1; bus.epu_addr_i = 4'd2; bus.epu_wdata_i = wd; #1;
    checks++; if (bus.epu_gnt_o !== 1'b1) begin errors++; $display("FAIL epu_rd_gnt: got %b expected 1", bus.epu_gnt_o); end
    checks++; if (sram_bus !== rd(4'd2, wd)) begin errors++; $display("FAIL epu_rd_sram: got %h expected %h", sram_bus, rd(4'd2, wd)); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({bus.epu_rvalid_o, bus.epu_rdata_o} !== {1'b1, 32'hA2}) begin
      errors++; $display("FAIL epu_rd_ret: got %b/%h expected 1/000000a2", bus.epu_rvalid_o, bus.epu_rdata_o); end
    checks++; if (sram_bus !== '0) begin errors++; $display("FAIL epu_rd_quiet: got %h expected 0", sram_bus); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({bus.epu_rvalid_o, bus.epu_rdata_o} !== 33'b0) begin
      errors++; $display("FAIL epu_rd_clear: got %b/%h expected 0/0", bus.epu_rvalid_o, bus.epu_rdata_o); end
  endtask

  task automatic test_start_collision();
    int n, acc, cyc;
    logic b;
    n = $urandom_range(1, 6);
    @(negedge clk); idle_inputs(); load_start = 1'b1; load_len = 5'(n);
    bus.epu_req_i = 1'b1; bus.epu_we_i = 1'b1; bus.epu_addr_i = 4'd5; #1;
    checks++; if (bus.epu_gnt_o !== 1'b0) begin errors++; $display("FAIL coll_gnt: got %b expected 0", bus.epu_gnt_o); end
    checks++; if (sram_bus !== '0) begin errors++; $display("FAIL coll_sram: got %h expected 0", sram_bus); end
    acc = 0; cyc = 0;
    while (acc < n && cyc < 200) begin
      @(negedge clk); idle_inputs();
      enb = ($urandom_range(0, 3) != 0);
      bus.ld_valid_i = 1'($urandom_range(0, 1));
      bus.ld_addr_i = 4'($urandom_range(0, 15));
      bus.ld_wdata_i = $urandom;
      bus.epu_req_i = 1'($urandom_range(0, 1));
      #1;
      b = enb & bus.ld_valid_i;
      checks++; if ({bus.ld_ready_o, bus.epu_gnt_o, state, ld_done} !== {enb, 1'b0, 2'b01, 1'b0}) begin
        errors++; $display("FAIL rload_ctrl: got %b expected %b", {bus.ld_ready_o, bus.epu_gnt_o, state, ld_done}, {enb, 4'b0010}); end
      checks++; if (sram_bus !== (b ? wr(bus.ld_addr_i, bus.ld_wdata_i) : 39'b0)) begin
        errors++; $display("FAIL rload_sram: got %h expected %h", sram_bus, (b ? wr(bus.ld_addr_i, bus.ld_wdata_i) : 39'b0)); end
      if (b) begin ref_mem[bus.ld_addr_i] = bus.ld_wdata_i; acc++; end
      cyc++;
    end
    if (acc < n) begin checks++; errors++; $display("FAIL rload_timeout: got %0d beats expected %0d", acc, n); end
    expect_done("rload");
  endtask

  task automatic test_epu_random();
    logic pend, g;
    logic [31:0] pdata;
    logic [38:0] eb;
    pend = 1'b0; pdata = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); idle_inputs();
      enb = ($urandom_range(0, 3) != 0);
      bus.epu_req_i = 1'($urandom_range(0, 1));
      bus.epu_we_i = 1'($urandom_range(0, 1));
      bus.epu_addr_i = 4'($urandom_range(0, 15));
      bus.epu_wdata_i = $urandom;
      #1;
      g = enb & bus.epu_req_i;
      eb = !g ? 39'b0 : (bus.epu_we_i ? wr(bus.epu_addr_i, bus.epu_wdata_i) : rd(bus.epu_addr_i, bus.epu_wdata_i));
      checks++; if (bus.epu_gnt_o !== g) begin errors++; $display("FAIL rnd_gnt: got %b expected %b", bus.epu_gnt_o, g); end
      checks++; if (sram_bus !== eb) begin errors++; $display("FAIL rnd_sram: got %h expected %h", sram_bus, eb); end
      checks++; if ({bus.epu_rvalid_o, bus.epu_rdata_o} !== {pend, pend ? pdata : 32'h0}) begin
        errors++; $display("FAIL rnd_ret: got %b/%h expected %b/%h", bus.epu_rvalid_o, bus.epu_rdata_o, pend, pend ? pdata : 32'h0); end
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL rnd_state: got %b expected 10", state); end
      pend = g & !bus.epu_we_i;
      if (pend) pdata = ref_mem[bus.epu_addr_i];
      if (g & bus.epu_we_i) ref_mem[bus.epu_addr_i] = bus.epu_wdata_i;
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({bus.epu_rvalid_o, bus.epu_rdata_o} !== {pend, pend ? pdata : 32'h0}) begin
      errors++; $display("FAIL rnd_drain: got %b/%h expected %b/%h", bus.epu_rvalid_o, bus.epu_rdata_o, pend, pend ? pdata : 32'h0); end
  endtask

  task automatic test_enable_freeze();
    @(negedge clk); idle_inputs(); enb = 1'b0; load_start = 1'b1; load_len = 5'd3; bus.epu_req_i = 1'b1; #1;
    checks++; if ({bus.epu_gnt_o, sram_bus} !== 40'b0) begin errors++; $display("FAIL frz_gnt: got %h expected 0", {bus.epu_gnt_o, sram_bus}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({state, bus.epu_rvalid_o} !== 3'b100) begin errors++; $display("FAIL frz_state: got %b expected 100", {state, bus.epu_rvalid_o}); end
  endtask

  task automatic test_zero_len();
    start_load(0);
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({state, ld_done, bus.sram_we_o} !== 4'b0100) begin errors++; $display("FAIL zero_load: got %b expected 0100", {state, ld_done, bus.sram_we_o}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({state, ld_done, bus.sram_we_o} !== 4'b1010) begin errors++; $display("FAIL zero_run: got %b expected 1010", {state, ld_done, bus.sram_we_o}); end
  endtask

  task automatic test_restart();
    start_load(3);
    beat(4'd7, $urandom, "rst1");
    @(negedge clk); idle_inputs(); load_start = 1'b1; load_len = 5'd2;
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 4'd8; bus.ld_wdata_i = $urandom; #1;
    checks++; if (sram_bus !== '0) begin errors++; $display("FAIL restart_ignored: got %h expected 0", sram_bus); end
    beat(4'd9, $urandom, "rst2");
    beat(4'd10, $urandom, "rst3");
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_len: got %b expected 01", state); end
    expect_done("restart");
  endtask

  task automatic test_reset_mid();
    start_load(4);
    beat(4'd11, $urandom, "mid1");
    beat(4'd12, $urandom, "mid2");
    @(negedge clk); idle_inputs(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs(); rst = 1'b1; #1;
      checks++; if ({state, ld_done} !== 3'b000) begin errors++; $display("FAIL midrst_abandon: got %b expected 000", {state, ld_done}); end
    end
    start_load(2);
    beat(4'd13, $urandom, "fresh1");
    beat(4'd14, $urandom, "fresh2");
    expect_done("fresh");
    @(negedge clk); idle_inputs(); rst = 1'b0; bus.epu_req_i = 1'b1; bus.epu_addr_i = 4'd13;
    @(negedge clk); idle_inputs(); rst = 1'b1; #1;
    checks++; if ({state, bus.epu_rvalid_o, bus.epu_rdata_o} !== 35'b0) begin
      errors++; $display("FAIL midread_abandon: got %h expected 0", {state, bus.epu_rvalid_o, bus.epu_rdata_o}); end
  endtask

  task automatic test_readback();
    logic rb_en;
`ifdef PARAM_ARB_READBACK_EN
    rb_en = 1'b1;
`else
    rb_en = 1'b0;
`endif
    start_load(2);
    @(negedge clk); idle_inputs(); bus.ld_valid_i = 1'b1; bus.ld_addr_i = 4'd0; bus.ld_wdata_i = 32'hA0;
    bus.rb_req_i = 1'b1; bus.rb_addr_i = 4'd0; #1;
    checks++; if (bus.rb_gnt_o !== 1'b0) begin errors++; $display("FAIL rb_coll_gnt: got %b expected 0", bus.rb_gnt_o); end
    checks++; if (sram_bus !== wr(4'd0, 32'hA0)) begin errors++; $display("FAIL rb_coll_sram: got %h expected %h", sram_bus, wr(4'd0, 32'hA0)); end
    ref_mem[0] = 32'hA0;
    @(negedge clk); idle_inputs(); bus.rb_req_i = 1'b1; bus.rb_addr_i = 4'd0; #1;
    checks++; if (bus.rb_gnt_o !== rb_en) begin errors++; $display("FAIL rb_gnt: got %b expected %b", bus.rb_gnt_o, rb_en); end
    checks++; if (sram_bus[38:32] !== (rb_en ? 7'b1100000 : 7'b0)) begin
      errors++; $display("FAIL rb_sram: got %b expected %b", sram_bus[38:32], (rb_en ? 7'b1100000 : 7'b0)); end
    @(negedge clk); idle_inputs(); bus.ld_valid_i = 1'b1; bus.ld_addr_i = 4'd1; bus.ld_wdata_i = 32'hA1; #1;
    checks++; if ({bus.rb_rvalid_o, bus.rb_rdata_o} !== (rb_en ? {1'b1, ref_mem[0]} : 33'b0)) begin
      errors++; $display("FAIL rb_ret: got %b/%h expected %b", bus.rb_rvalid_o, bus.rb_rdata_o, rb_en); end
    ref_mem[1] = 32'hA1;
    expect_done("rb");
    checks++; if ({bus.rb_rvalid_o, bus.rb_rdata_o} !== 33'b0) begin
      errors++; $display("FAIL rb_clear: got %b/%h expected 0/0", bus.rb_rvalid_o, bus.rb_rdata_o); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    bus.sram_rdata_i = '0;
    test_reset();
    test_idle();
    test_load_basic();
    test_epu_read();
    test_start_collision();
    test_epu_random();
    test_enable_freeze();
    test_zero_len();
    test_restart();
    test_epu_random();
    test_reset_mid();
    test_readback();
    test_epu_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
